// File: rtl/level_decode_sequencer.sv
// Level decode sequencer: walks one coefficient block level by level, handing codes to the
// level processing unit and adapting the suffix length from the levels it returns.
module level_decode_sequencer #(
    parameter int MAX_SUFFIX = 6
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic        Start,
    input  logic [4:0]  TotalCoeff,
    input  logic [1:0]  TrailingOnes,
    input  logic        CodeValid,
    input  logic [13:0] CodeNum,
    output logic        CodeReady,
    output logic        LpuTrig,
    output logic        LpuTrailingOneMode,
    output logic [1:0]  LpuTrailingOnes,
    output logic [2:0]  LpuSuffixLength,
    output logic [13:0] LpuCodeNum,
    input  logic [12:0] LpuLevelOut,
    input  logic        LpuWrReq,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_TRIG,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [2:0] MAX_SFX = 3'(MAX_SUFFIX);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  total_q, total_d;
    logic [1:0]  t1_q, t1_d;
    logic [1:0]  eff_t1_q, eff_t1_d;
    logic [2:0]  suffix_q, suffix_d;
    logic [13:0] code_q, code_d;

    logic        t1_mode;
    logic [4:0]  cnt_inc;
    logic [12:0] level_mag;
    logic [12:0] threshold;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            total_q  <= '0;
            t1_q     <= '0;
            eff_t1_q <= '0;
            suffix_q <= '0;
            code_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            total_q  <= total_d;
            t1_q     <= t1_d;
            eff_t1_q <= eff_t1_d;
            suffix_q <= suffix_d;
            code_q   <= code_d;
        end
    end

    // Magnitude is taken as unsigned 13 bits so that -4096 yields 4096 rather than wrapping.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        total_d   = total_q;
        t1_d      = t1_q;
        eff_t1_d  = eff_t1_q;
        suffix_d  = suffix_q;
        code_d    = code_q;

        t1_mode   = (cnt_q < {3'b000, eff_t1_q});
        cnt_inc   = cnt_q + 5'd1;
        level_mag = LpuLevelOut[12] ? (~LpuLevelOut + 13'd1) : LpuLevelOut;
        threshold = 13'd3 << (suffix_q - 3'd1);

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    total_d  = TotalCoeff;
                    t1_d     = TrailingOnes;
                    eff_t1_d = (TotalCoeff < {3'b000, TrailingOnes}) ? TotalCoeff[1:0] : TrailingOnes;
                    cnt_d    = '0;
                    suffix_d = ((TotalCoeff > 5'd10) && (TrailingOnes != 2'd3)) ? 3'd1 : 3'd0;
                    state_d  = (TotalCoeff == 5'd0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (CodeValid) begin
                    code_d  = CodeNum;
                    state_d = S_TRIG;
                end
            end
            S_TRIG: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (LpuWrReq) begin
                    cnt_d = cnt_inc;
                    if (!t1_mode) begin
                        if (suffix_q == 3'd0) begin
                            suffix_d = 3'd1;
                        end else if ((level_mag > threshold) && (suffix_q < MAX_SFX)) begin
                            suffix_d = suffix_q + 3'd1;
                        end
                    end
                    state_d = (cnt_inc == total_q) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign CodeReady          = (state_q == S_ISSUE);
    assign LpuTrig            = (state_q == S_TRIG);
    assign Busy               = (state_q != S_IDLE);
    assign Done               = (state_q == S_DONE);
    assign LpuTrailingOneMode = t1_mode;
    assign LpuTrailingOnes    = t1_q;
    assign LpuSuffixLength    = suffix_q;
    assign LpuCodeNum         = code_q;

endmodule
